multicycle_mainfsm: RTL and testbench

- Main control FSM for the multicycle ARM datapath. It sequences fetch, decode, memory and ALU phases over one shared ALU/memory port.
- Emits per-state datapath selects plus raw RegW/MemW/Branch/FlagW requests.
- The condition-check logic gates those requests with CondEx; this block never inspects flags.
- Also contains the ALU decoder (Funct → ALUControl/FlagW) so the full control path is in one place.

---
 rtl/multicycle_mainfsm.sv | 247 ++++++++++++++++++++++++
 tb/tb_multicycle_mainfsm.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mainfsm.sv
// -----------------------------------------------------------------------------
// multicycle_mainfsm
//
// Main control FSM for the multicycle ARM datapath, with the ALU decoder.
// It sequences fetch, decode, memory and ALU phases over the single shared
// ALU/memory port. It emits per-state datapath selects plus raw RegW, MemW,
// Branch and FlagW requests. The condition-check logic gates those requests
// downstream, so this block never looks at the flags.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset; forces FETCH
//   Op          Instr[27:26]: 00 data-proc, 01 memory, 10 branch, 11 undefined
//   Funct       Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (data-proc) / L (memory)
//   IRWrite     load the instruction register
//   NextPC      unconditional PC update (fetch)
//   AdrSrc      memory address select: 0=PC, 1=ALU result
//   ALUSrcA     ALU A select: 00=RD1, 01=PC
//   ALUSrcB     ALU B select: 00=RD2/shifted, 01=ExtImm, 10=constant 4
//   ResultSrc   result select: 00=ALUOut, 01=Data, 10=ALU result direct
//   RegW        register write request (before the condition check)
//   MemW        memory write request (before the condition check)
//   Branch      branch request (before the condition check)
//   ALUControl  00 add, 01 sub, 10 and, 11 orr
//   FlagW       [1]=write N,Z; [0]=write C,V
//   Undef       undefined-instruction trap (only with MAINFSM_UNDEF_TRAP_EN)
//
// Optional feature (macro MAINFSM_UNDEF_TRAP_EN):
//   With the macro, an Op=11 instruction enters TRAP and asserts Undef until
//   reset. Without the macro, the instruction is skipped and the FSM returns to
//   FETCH straight after DECODE.
// -----------------------------------------------------------------------------
module multicycle_mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW
`ifdef MAINFSM_UNDEF_TRAP_EN
    ,
    output logic       Undef
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
`ifdef MAINFSM_UNDEF_TRAP_EN
        ,
        S_TRAP     = 4'd10
`endif
    } state_e;

    // These are the per-state control bits. They are registered together with
    // the state, so every output changes cleanly on the clock edge.
    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
`ifdef MAINFSM_UNDEF_TRAP_EN
        logic       undef;
`endif
    } ctrl_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    logic [3:0] cmd;
    logic       s_bit;

    assign cmd   = Funct[4:1];
    assign s_bit = Funct[0];

    // Control word for a given state. ALUWB needs cmd so that CMP can
    // suppress the register write. cmd comes from the IR, which holds it
    // stable across the whole instruction.
    function automatic ctrl_t decode_state(input state_e s, input logic [3:0] c);
        ctrl_t r;
        // NOTE: start from all-zero so every field is assigned on every path;
        // combinational logic with an unassigned path infers a latch.
        r = '0;
        case (s)
            S_FETCH: begin
                r.ir_write   = 1'b1;
                r.next_pc    = 1'b1;
                r.alu_src_a  = 2'b01;
                r.alu_src_b  = 2'b10;
                r.result_src = 2'b10;
            end
            S_DECODE: begin
                r.alu_src_a  = 2'b01;
                r.alu_src_b  = 2'b10;
                r.result_src = 2'b10;
            end
            S_MEMADR: begin
                r.alu_src_b  = 2'b01;
            end
            S_MEMREAD: begin
                r.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                r.result_src = 2'b01;
                r.reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                r.adr_src    = 1'b1;
                r.mem_w      = 1'b1;
            end
            S_EXECUTER: begin
                r.alu_op     = 1'b1;
            end
            S_EXECUTEI: begin
                r.alu_src_b  = 2'b01;
                r.alu_op     = 1'b1;
            end
            S_ALUWB: begin
                r.reg_w      = (c != CMD_CMP);
            end
            S_BRANCH: begin
                r.alu_src_b  = 2'b01;
                r.result_src = 2'b10;
                r.branch     = 1'b1;
            end
`ifdef MAINFSM_UNDEF_TRAP_EN
            S_TRAP: begin
                r.undef      = 1'b1;
            end
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
`ifdef MAINFSM_UNDEF_TRAP_EN
                    default: state_d = S_TRAP;
`else
                    default: state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
`ifdef MAINFSM_UNDEF_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            // MEMWB, MEMWRITE, ALUWB, BRANCH and any unencoded value go to FETCH.
            default:    state_d = S_FETCH;
        endcase
    end

    // The outputs are decoded from the next state, so the registered copy
    // always matches the state it is stored with.
    assign ctrl_d = decode_state(state_d, cmd);

    // State register and registered control outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // flop samples values from before the edge, whatever the statement order.
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode_state(S_FETCH, 4'b0000);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // ALU decoder. This is the only path from an input to an output; it is
    // qualified by the registered ALUOp bit.
    always_comb begin
        ALUControl = 2'b00;
        FlagW      = 2'b00;
        if (ctrl_q.alu_op) begin
            case (cmd)
                CMD_ADD: ALUControl = 2'b00;
                CMD_SUB: ALUControl = 2'b01;
                CMD_AND: ALUControl = 2'b10;
                CMD_ORR: ALUControl = 2'b11;
                CMD_CMP: ALUControl = 2'b01;
                default: ALUControl = 2'b00;
            endcase
            FlagW[1] = s_bit;
            FlagW[0] = s_bit & ((cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP));
            // CMP exists only to set flags, so it writes all of them even with S=0.
            if (cmd == CMD_CMP) begin
                FlagW = 2'b11;
            end
        end
    end

    assign IRWrite   = ctrl_q.ir_write;
    assign NextPC    = ctrl_q.next_pc;
    assign AdrSrc    = ctrl_q.adr_src;
    assign ALUSrcA   = ctrl_q.alu_src_a;
    assign ALUSrcB   = ctrl_q.alu_src_b;
    assign ResultSrc = ctrl_q.result_src;
    assign RegW      = ctrl_q.reg_w;
    assign MemW      = ctrl_q.mem_w;
    assign Branch    = ctrl_q.branch;
`ifdef MAINFSM_UNDEF_TRAP_EN
    assign Undef     = ctrl_q.undef;
`endif

endmodule

// File: tb/tb_multicycle_mainfsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_mainfsm
//
// Directed bench for multicycle_mainfsm. Each instruction pushes the expected
// output word for every cycle it should take into a scoreboard queue. The bench
// then pops one entry per clock and compares it with the DUT outputs. Expected
// words come from a reference table of the state outputs and the ALU decoder.
// -----------------------------------------------------------------------------
module tb_multicycle_mainfsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite, NextPC, AdrSrc, RegW, MemW, Branch;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW;
    logic       undef_obs;

    multicycle_mainfsm dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .IRWrite    (IRWrite),
        .NextPC     (NextPC),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .RegW       (RegW),
        .MemW       (MemW),
        .Branch     (Branch),
        .ALUControl (ALUControl),
        .FlagW      (FlagW)
`ifdef MAINFSM_UNDEF_TRAP_EN
        ,
        .Undef      (undef_obs)
`endif
    );

`ifndef MAINFSM_UNDEF_TRAP_EN
    assign undef_obs = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_TRAP
    } st_e;

    typedef struct {
        st_e        st;
        logic [16:0] v;
    } sb_item_t;

    sb_item_t sb[$];
    int checks = 0;
    int passed = 0;

    // Expected word: {Undef, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB,
    //                 ResultSrc, RegW, MemW, Branch, ALUControl, FlagW}
    function automatic logic [16:0] exp_out(input st_e s, input logic [5:0] f);
        logic       un, ir, np, adr, rw, mw, br, aluop;
        logic [1:0] sa, sbx, rs, ac, fw;
        logic [3:0] cmd;
        cmd = f[4:1];
        {un, ir, np, adr, rw, mw, br, aluop} = '0;
        {sa, sbx, rs, ac, fw} = '0;
        case (s)
            S_FETCH:    begin ir = 1; np = 1; sa = 2'b01; sbx = 2'b10; rs = 2'b10; end
            S_DECODE:   begin sa = 2'b01; sbx = 2'b10; rs = 2'b10; end
            S_MEMADR:   begin sbx = 2'b01; end
            S_MEMREAD:  begin adr = 1; end
            S_MEMWB:    begin rs = 2'b01; rw = 1; end
            S_MEMWRITE: begin adr = 1; mw = 1; end
            S_EXECR:    begin aluop = 1; end
            S_EXECI:    begin sbx = 2'b01; aluop = 1; end
            S_ALUWB:    begin rw = (cmd != 4'b1010); end
            S_BRANCH:   begin sbx = 2'b01; rs = 2'b10; br = 1; end
            S_TRAP:     begin un = 1; end
            default:    ;
        endcase
        if (aluop) begin
            unique case (cmd)
                4'b0100: begin ac = 2'b00; fw = {f[0], f[0]}; end
                4'b0010: begin ac = 2'b01; fw = {f[0], f[0]}; end
                4'b1010: begin ac = 2'b01; fw = 2'b11;        end
                4'b0000: begin ac = 2'b10; fw = {f[0], 1'b0}; end
                4'b1100: begin ac = 2'b11; fw = {f[0], 1'b0}; end
                default: begin ac = 2'b00; fw = {f[0], 1'b0}; end
            endcase
        end
        return {un, ir, np, adr, sa, sbx, rs, rw, mw, br, ac, fw};
    endfunction

    function automatic logic [16:0] observed();
        return {undef_obs, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                RegW, MemW, Branch, ALUControl, FlagW};
    endfunction

    task automatic push(input st_e s);
        sb_item_t it;
        it.st = s;
        it.v  = exp_out(s, Funct);
        sb.push_back(it);
    endtask

    task automatic check_pop();
        sb_item_t    it;
        logic [16:0] obs;
        checks++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: got nothing to compare, required an entry");
        end else begin
            it  = sb.pop_front();
            obs = observed();
            assert (obs === it.v) passed++;
            else $error("FAIL %s: got %b, required %b", it.st.name(), obs, it.v);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            check_pop();
            tick();
        end
    endtask

    // Drive one instruction and queue the state path it should follow, from
    // its FETCH up to (but not including) the next FETCH.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct);
        Op    = op;
        Funct = funct;
        push(S_FETCH);
        push(S_DECODE);
        case (op)
            2'b00: begin
                push(funct[5] ? S_EXECI : S_EXECR);
                push(S_ALUWB);
            end
            2'b01: begin
                push(S_MEMADR);
                if (funct[0]) begin
                    push(S_MEMREAD);
                    push(S_MEMWB);
                end else begin
                    push(S_MEMWRITE);
                end
            end
            2'b10: push(S_BRANCH);
            default: ;
        endcase
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        Op    = 2'b00;
        Funct = 6'b000000;
        tick();
        tick();
        reset = 1'b0;

        // ADD reg, no S: FETCH values right after reset, then DECODE.
        run_instr(2'b00, 6'b001000);
        // LDR
        run_instr(2'b01, 6'b011001);
        // STR
        run_instr(2'b01, 6'b011000);
        // SUBS reg
        run_instr(2'b00, 6'b000101);
        // CMP with S=1 and with S=0: flags are always written, no register write.
        run_instr(2'b00, 6'b010101);
        run_instr(2'b00, 6'b010100);
        // ANDS imm, ORR reg, unknown cmd 0110 with S
        run_instr(2'b00, 6'b100001);
        run_instr(2'b00, 6'b011000);
        run_instr(2'b00, 6'b001101);
        // B
        run_instr(2'b10, 6'b000000);

        // Reset during MEMREAD of an LDR abandons it: FETCH next, no MEMWB.
        Op    = 2'b01;
        Funct = 6'b011001;
        push(S_FETCH);
        push(S_DECODE);
        push(S_MEMADR);
        push(S_MEMREAD);
        for (int i = 0; i < 3; i++) begin
            check_pop();
            tick();
        end
        check_pop();
        reset = 1'b1;
        tick();
        reset = 1'b0;

`ifdef MAINFSM_UNDEF_TRAP_EN
        // Undefined opcode traps and holds Undef until reset.
        Op    = 2'b11;
        Funct = 6'b000000;
        push(S_FETCH);
        push(S_DECODE);
        for (int i = 0; i < 4; i++) push(S_TRAP);
        drain();
        reset = 1'b1;
        tick();
        reset = 1'b0;
`else
        // Undefined opcode is skipped: FETCH again two cycles later.
        run_instr(2'b11, 6'b000000);
`endif
        // Final FETCH after the last instruction.
        Op    = 2'b00;
        Funct = 6'b000000;
        push(S_FETCH);
        check_pop();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
